// File: rtl/sm_add_pkg.sv
// sm_add_pkg: shared defaults and helpers for the arbitrated sign-magnitude adder
package sm_add_pkg;
   localparam int SM_N    = 4;
   localparam int SM_NREQ = 4;
   localparam int SM_IDW  = 2;
   function automatic logic mag_ovf(input logic [15:0] ma, input logic [15:0] mb, input int w);
      logic [16:0] s;
      logic [16:0] t;
      s = {1'b0, ma} + {1'b0, mb};
      t = s >> w;
      return t[0];
   endfunction
   function automatic logic [2:0] idx_inc(input logic [2:0] i, input int n);
      return (int'(i) + 1 >= n) ? 3'd0 : i + 3'd1;
   endfunction
endpackage

// File: rtl/sign_mag_add.sv
// sign_mag_add: combinational sign-magnitude adder, equal magnitudes take the sign of b
module sign_mag_add #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum
);
   logic [N-2:0] ma, mb;
   assign ma  = a[N-2:0];
   assign mb  = b[N-2:0];
   assign sum = (a[N-1] == b[N-1]) ? {a[N-1], ma + mb} :
                (ma > mb)          ? {a[N-1], ma - mb} : {b[N-1], mb - ma};
endmodule

// File: rtl/sm_add_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant searching upward from the index after ptr
module rr_arbiter import sm_add_pkg::*; #(
   parameter int NREQ = SM_NREQ,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);
   // first asserted request after ptr wins, wrapping modulo NREQ
   always_comb begin
      logic [IDW-1:0] j;
      logic           found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = ptr;
      for (int k = 0; k < NREQ; k++) begin
         j = IDW'(idx_inc(3'(j), NREQ));
         if (enable && !found && req[j]) begin
            grant[j] = 1'b1;
            idx      = j;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sm_add_arbiter.sv
// sm_add_arbiter: round-robin shared sign-magnitude adder with operand and result stages
module sm_add_arbiter import sm_add_pkg::*; #(
   parameter int N    = SM_N,
   parameter int NREQ = SM_NREQ,
   parameter int IDW  = SM_IDW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] a_in,
   input  logic [NREQ*N-1:0] b_in,
   output logic [NREQ-1:0]   ack,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDW-1:0]    res_id,
   output logic [N-1:0]      res_sum,
   output logic              res_ovf
);
   logic           op_valid, res_free, op_free;
   logic [N-1:0]   op_a, op_b, ga, gb, sum;
   logic [IDW-1:0] op_id, ptr, gidx;
   assign res_free = !res_valid || res_ready;
   assign op_free  = !op_valid || res_free;
   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .ptr    (ptr),
      .enable (op_free && !reset),
      .grant  (ack),
      .idx    (gidx)
   );
   sign_mag_add #(.N(N)) u_add (
      .a   (op_a),
      .b   (op_b),
      .sum (sum)
   );
   // operand mux for the granted requester
   always_comb begin
      ga = '0;
      gb = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ack[i]) begin
            ga = a_in[i*N +: N];
            gb = b_in[i*N +: N];
         end
      end
   end
   // operand stage: capture on grant, empty when handed on without a refill
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_id    <= '0;
         ptr      <= IDW'(NREQ - 1);
      end else if (|ack) begin
         op_valid <= 1'b1;
         op_a     <= ga;
         op_b     <= gb;
         op_id    <= gidx;
         ptr      <= gidx;
      end else if (res_free) begin
         op_valid <= 1'b0;
      end
   end
   // result stage: load from operand stage, clear valid when consumed with nothing behind
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_id    <= '0;
         res_ovf   <= 1'b0;
      end else if (op_valid && res_free) begin
         res_valid <= 1'b1;
         res_sum   <= sum;
         res_id    <= op_id;
         res_ovf   <= (op_a[N-1] == op_b[N-1]) && mag_ovf(16'(op_a[N-2:0]), 16'(op_b[N-2:0]), N - 1);
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sm_add_arbiter.sv
// tb_sm_add_arbiter: scoreboard bench for the round-robin sign-magnitude adder
module tb_sm_add_arbiter;
   typedef struct packed {
      logic [1:0] id;
      logic [3:0] sum;
      logic       ovf;
   } ent_t;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] a_in, b_in;
   logic [3:0]  ack;
   logic        res_valid, res_ready, res_ovf;
   logic [1:0]  res_id;
   logic [3:0]  res_sum;
   logic [3:0]  av [4];
   logic [3:0]  bv [4];
   logic [3:0]  es [4];
   logic        eo [4];
   ent_t        q [$];
   int          errors = 0;
   int          checks = 0;
   sm_add_arbiter #(.N(4), .NREQ(4), .IDW(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .ack       (ack),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_sum   (res_sum),
      .res_ovf   (res_ovf)
   );
   always #5 clk = ~clk;
   always_comb begin
      a_in = '0;
      b_in = '0;
      for (int i = 0; i < 4; i++) begin
         a_in[i*4 +: 4] = av[i];
         b_in[i*4 +: 4] = bv[i];
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic adv();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_ack(input logic [3:0] e, input bit push);
      @(negedge clk);
      chk("ack", 32'(ack), 32'(e));
      if (push)
         for (int i = 0; i < 4; i++)
            if (e[i]) q.push_back('{id: 2'(i), sum: es[i], ovf: eo[i]});
   endtask
   task automatic setop(input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic o);
      av[i] = a;
      bv[i] = b;
      es[i] = s;
      eo[i] = o;
   endtask
   // monitor: every accepted result must match the oldest expected entry
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_result", 32'(res_valid), 32'(0));
            end else begin
               e = q.pop_front();
               chk("res_id", 32'(res_id), 32'(e.id));
               chk("res_sum", 32'(res_sum), 32'(e.sum));
               chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1;
      req = '0;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) setop(i, 4'h0, 4'h0, 4'h0, 1'b0);
      repeat (2) adv();
      chk("rst_valid", 32'(res_valid), 32'(0));
      chk("rst_sum", 32'(res_sum), 32'(0));
      chk("rst_id", 32'(res_id), 32'(0));
      chk("rst_ovf", 32'(res_ovf), 32'(0));
      chk("rst_ack", 32'(ack), 32'(0));
      reset = 1'b0;
      // single requester, +3 + -2, two-edge latency
      setop(0, 4'b0011, 4'b1010, 4'b0001, 1'b0);
      req = 4'b0001;
      chk_ack(4'b0001, 1);
      adv();
      req = 4'b0000;
      chk_ack(4'b0000, 0);
      chk("lat_not_yet", 32'(res_valid), 32'(0));
      adv();
      chk_ack(4'b0000, 0);
      chk("lat_valid", 32'(res_valid), 32'(1));
      adv();
      // overflow +5 + +4, then +3 + -3 giving negative zero
      setop(0, 4'b0101, 4'b0100, 4'b0001, 1'b1);
      req = 4'b0001;
      chk_ack(4'b0001, 1);
      adv();
      setop(0, 4'b0011, 4'b1011, 4'b1000, 1'b0);
      chk_ack(4'b0001, 1);
      adv();
      req = 4'b0000;
      repeat (3) begin chk_ack(4'b0000, 0); adv(); end
      // fairness from reset with all requests held
      reset = 1'b1;
      repeat (2) adv();
      reset = 1'b0;
      setop(0, 4'b0001, 4'b0001, 4'b0010, 1'b0);
      setop(1, 4'b1010, 4'b1011, 4'b1101, 1'b0);
      setop(2, 4'b0111, 4'b1001, 4'b0110, 1'b0);
      setop(3, 4'b1110, 4'b0010, 4'b1100, 1'b0);
      req = 4'b1111;
      chk_ack(4'b0001, 1); adv();
      chk_ack(4'b0010, 1); adv();
      chk_ack(4'b0100, 1); adv();
      chk_ack(4'b1000, 1); adv();
      chk_ack(4'b0001, 1); adv();
      req = 4'b0000;
      repeat (3) begin chk_ack(4'b0000, 0); adv(); end
      // backpressure: two acks fill both stages, then hold
      res_ready = 1'b0;
      req = 4'b0011;
      chk_ack(4'b0010, 1); adv();
      req = 4'b0001;
      chk_ack(4'b0001, 1); adv();
      req = 4'b0000;
      repeat (3) begin
         chk_ack(4'b0000, 0);
         chk("bp_valid", 32'(res_valid), 32'(1));
         chk("bp_sum", 32'(res_sum), 32'(4'b1101));
         chk("bp_id", 32'(res_id), 32'(1));
         adv();
      end
      res_ready = 1'b1;
      repeat (2) begin chk_ack(4'b0000, 0); adv(); end
      @(negedge clk);
      chk("bp_drained", 32'(res_valid), 32'(0));
      adv();
      // reset while both stages hold work that must be discarded
      res_ready = 1'b0;
      req = 4'b0011;
      chk_ack(4'b0010, 0); adv();
      req = 4'b0001;
      chk_ack(4'b0001, 0); adv();
      req = 4'b0000;
      chk_ack(4'b0000, 0);
      chk("pre_rst_valid", 32'(res_valid), 32'(1));
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(res_valid), 32'(0));
      chk("arst_sum", 32'(res_sum), 32'(0));
      chk("arst_id", 32'(res_id), 32'(0));
      chk("arst_ovf", 32'(res_ovf), 32'(0));
      req = 4'b1001;
      res_ready = 1'b1;
      #1;
      chk("arst_ack", 32'(ack), 32'(0));
      adv();
      reset = 1'b0;
      chk_ack(4'b0001, 1); adv();
      req = 4'b1000;
      chk_ack(4'b1000, 1); adv();
      req = 4'b0000;
      repeat (3) begin chk_ack(4'b0000, 0); adv(); end
      // pointer wrap 3 -> 0 with overflowing operands
      setop(3, 4'b0111, 4'b0111, 4'b0110, 1'b1);
      setop(0, 4'b1111, 4'b1001, 4'b1000, 1'b1);
      req = 4'b1000;
      chk_ack(4'b1000, 1); adv();
      req = 4'b0001;
      chk_ack(4'b0001, 1); adv();
      req = 4'b0000;
      repeat (4) begin chk_ack(4'b0000, 0); adv(); end
      chk("end_valid", 32'(res_valid), 32'(0));
      chk("sb_empty", 32'(q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
